// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Three-requester arbiter for a single synchronous-read memory port.
//   Requesters are a read-only instruction fetch port (if_*), a data port
//   (d_*) and a debug/loader port (dbg_*). Each access takes two cycles:
//   MEM (grant pulse, memory enabled) followed by RESP (valid pulse, read
//   data forwarded). Priority is dbg > d > if. A 4-bit starvation counter
//   lets fetch win outright once it has lost MAX_WAIT arbitrations in a row.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   if_req/if_addr                fetch request and address
//   if_gnt/if_valid               fetch grant pulse / data-valid pulse
//   d_req/d_we/d_addr/d_wdata     data-port request
//   d_gnt/d_valid                 data grant pulse / completion pulse
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  debug-port request
//   dbg_gnt/dbg_valid             debug grant pulse / completion pulse
//   rdata                         shared read data, nonzero only in RESP
//   mem_en/mem_we/mem_addr/mem_wdata   memory command, nonzero only in MEM
//   mem_rdata                     memory read data (one cycle after mem_en)
//   arb_state                     current FSM state encoding
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_valid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_RESP = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10,
    OWN_DBG  = 2'b11
  } owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // The state register is a plain vector so the unused encoding 2'b11 is
  // representable and recoverable.
  logic [1:0]    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    starve_q, starve_d;
  logic [3:0]    starve_inc_s;

  // Saturating increment of the fetch starvation counter.
  assign starve_inc_s = (starve_q < MAX_WAIT_C) ? (starve_q + 4'd1) : starve_q;

  // State, owner, captured request and starvation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= {AW{1'b0}};
      we_q     <= 1'b0;
      wdata_q  <= {DW{1'b0}};
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic: arbitration happens only from IDLE or RESP.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (if_req && (starve_q == MAX_WAIT_C)) begin
          // Starved fetch overrides the normal priority order.
          state_d  = ST_MEM;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = {DW{1'b0}};
          starve_d = 4'd0;
        end else if (dbg_req) begin
          state_d = ST_MEM;
          owner_d = OWN_DBG;
          addr_d  = dbg_addr;
          we_d    = dbg_we;
          wdata_d = dbg_wdata;
          if (if_req) begin
            starve_d = starve_inc_s;
          end else begin
            starve_d = starve_q;
          end
        end else if (d_req) begin
          state_d = ST_MEM;
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (if_req) begin
            starve_d = starve_inc_s;
          end else begin
            starve_d = starve_q;
          end
        end else if (if_req) begin
          state_d  = ST_MEM;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = {DW{1'b0}};
          starve_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_MEM: begin
        state_d = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Output decode: everything is derived from registers except rdata, which
  // forwards the memory output during RESP.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    dbg_gnt   = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    dbg_valid = 1'b0;
    rdata     = {DW{1'b0}};
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    case (state_q)
      ST_MEM: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_gnt    = (owner_q == OWN_IF);
        d_gnt     = (owner_q == OWN_D);
        dbg_gnt   = (owner_q == OWN_DBG);
      end
      ST_RESP: begin
        rdata     = mem_rdata;
        if_valid  = (owner_q == OWN_IF);
        d_valid   = (owner_q == OWN_D);
        dbg_valid = (owner_q == OWN_DBG);
      end
      default: begin
        rdata = {DW{1'b0}};
      end
    endcase
  end

  assign arb_state = state_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 8, address width; DW, 16, data width; MAX_WAIT, 3, fetch-starvation limit in lost arbitrations (legal 1..15).
REQ-002 The module SHALL provide these ports (name  direction  width  meaning):
 clk  in  1  single clock, rising-edge active
 reset  in  1  asynchronous, active-high reset
 if_req  in  1  instruction-fetch request (read only)
 if_addr  in  AW  fetch address
 if_gnt  out  1  fetch granted, one-cycle pulse
 if_valid  out  1  fetch data valid, one-cycle pulse
 d_req, d_we  in  1 each  data-port request; write enable
 d_addr, d_wdata  in  AW, DW  data-port address; write data
 d_gnt, d_valid  out  1 each  data grant pulse; completion pulse (read data or write ack)
 dbg_req, dbg_we  in  1 each  debug/loader request; write enable
 dbg_addr, dbg_wdata  in  AW, DW  debug address; write data
 dbg_gnt, dbg_valid  out  1 each  debug grant pulse; completion pulse
 rdata  out  DW  read data shared by all requesters, qualified by *_valid
 mem_en, mem_we  out  1 each  memory enable; write enable
 mem_addr, mem_wdata  out  AW, DW  memory address; write data
 mem_rdata  in  DW  synchronous-read memory output, valid the cycle after mem_en
 arb_state  out  2  current FSM state encoding (debug visibility)

Function
REQ-003 The FSM SHALL have states IDLE=2'b00, MEM=2'b01, RESP=2'b10; encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-004 Arbitration SHALL occur only at a rising edge while in IDLE or RESP; with no request pending the next state SHALL be IDLE.
REQ-005 Priority SHALL be dbg > d > if, except that when the starvation counter equals MAX_WAIT and if_req=1, fetch SHALL win over all others.
REQ-006 On a winning arbitration the FSM SHALL enter MEM and, for exactly that cycle, assert the winner's *_gnt and drive mem_en=1, mem_addr/mem_we/mem_wdata from registered copies of the winner's inputs (mem_we=0 for fetch).
REQ-007 MEM SHALL always advance to RESP; in RESP the owner's *_valid SHALL be 1 for one cycle and rdata SHALL equal mem_rdata (rdata SHALL be 0 in every other cycle).
REQ-008 Latency SHALL be: request sampled at edge E0 -> gnt during cycle E0..E1 -> valid during E1..E2; peak throughput one access per two cycles, back-to-back via RESP->MEM.
REQ-009 Outside MEM, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-010 Requesters SHALL hold req, addr, we, wdata stable until gnt and deassert req by the end of the gnt cycle; req still high at the edge ending RESP SHALL count as a new request.
REQ-011 The 4-bit starvation counter SHALL increment (saturating at MAX_WAIT) at each arbitration where if_req=1 and fetch loses, SHALL clear when fetch is granted, and SHALL hold otherwise.
REQ-012 At most one *_gnt and at most one *_valid SHALL be high in any cycle; gnt and valid of the same requester SHALL never coincide.
REQ-013 Requests arriving during MEM SHALL be ignored until the next arbitration edge (no queuing beyond the req level).

Reset
REQ-014 Asserting reset SHALL immediately (asynchronously) force state IDLE, starvation counter 0, and every output (gnt, valid, rdata, mem_*, arb_state) to 0.
REQ-015 Reset during MEM or RESP SHALL abandon the access with no *_valid issued; after reset deasserts, the first arbitration SHALL occur at the first rising edge with reset low.

Verification
REQ-016 Single fetch: if_req=1, if_addr=8'h10, memory holds 16'hBEEF -> if_gnt one cycle later for one cycle, mem_addr=8'h10, mem_en=1; next cycle if_valid=1, rdata=16'hBEEF.
REQ-017 Data write: d_req=1, d_we=1, d_addr=8'h20, d_wdata=16'h1234 -> d_gnt with mem_we=1, mem_wdata=16'h1234; d_valid next cycle; subsequent fetch of 8'h20 returns 16'h1234.
REQ-018 Simultaneous dbg_req, d_req, if_req held until granted -> grant order dbg, d, if, grants spaced exactly two cycles apart.
REQ-019 Starvation: if_req and d_req held high continuously, MAX_WAIT=3 -> d granted 3 times, then if_gnt, then d, counter back to 0.
REQ-020 Reset asserted mid-MEM of a d read -> all outputs 0 same cycle, no d_valid; after release with d_req=1 -> fresh d_gnt at first edge.
REQ-021 Illegal state 2'b11 forced -> IDLE next edge, no gnt or valid issued.
